// File: rtl/req_grnt_arb_pkg.sv
// Shared types and helpers for the request/grant arbiter family.
package req_grnt_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDelay = 2'd1,
      StGrant = 2'd2
   } state_e;

   // Widest configuration the helper below supports (N_CH up to 16).
   localparam int unsigned MaxCh  = 16;
   localparam int unsigned MaxIdW = 4;

   // Round-robin find-first-set: scans upward from ptr, wrapping at n_ch-1.
   // Returns {found, index}. Bits of req at or above n_ch are ignored.
   function automatic logic [MaxIdW:0] rr_ffs(input logic [MaxCh-1:0]  req,
                                              input logic [MaxIdW-1:0] ptr,
                                              input int unsigned       n_ch);
      logic              found;
      logic [MaxIdW-1:0] idx;
      int unsigned       c;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < MaxCh; k++) begin
         c = 32'(ptr) + k;
         if (c >= n_ch) c = c - n_ch;
         if (k < n_ch && !found && req[c[MaxIdW-1:0]]) begin
            found = 1'b1;
            idx   = c[MaxIdW-1:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/req_grnt_arb_if.sv
// Handshake bundle between requesting masters and the arbiter.
interface req_grnt_arb_if
   import req_grnt_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 4
);
   localparam int unsigned ID_W = $clog2(N_CH);

   logic [N_CH-1:0]  req;
   logic [CNT_W-1:0] dly_cfg;
   logic [CNT_W-1:0] hold_cfg;
   logic [N_CH-1:0]  grnt;
   logic [ID_W-1:0]  grnt_id;
   logic             busy;
   logic             hold_exp;
   logic             abandon;

   // Requesters / configuration side.
   modport master (
      output req, dly_cfg, hold_cfg,
      input  grnt, grnt_id, busy, hold_exp, abandon
   );

   // Arbiter side.
   modport slave (
      input  req, dly_cfg, hold_cfg,
      output grnt, grnt_id, busy, hold_exp, abandon
   );

endinterface

// File: rtl/req_grnt_arb_rr_pick.sv
// Combinational round-robin priority picker over N_CH requests.
module rr_pick
   import req_grnt_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   parameter int unsigned ID_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic            valid_o,
   output logic [ID_W-1:0] idx_o
);

   logic [MaxCh-1:0]  req_ext;
   logic [MaxIdW-1:0] ptr_ext;
   logic [MaxIdW:0]   res;
   logic              unused_res;

   // Widen to the helper's fixed width and pick the first set bit from ptr.
   always_comb begin
      req_ext    = MaxCh'(req_i);
      ptr_ext    = MaxIdW'(ptr_i);
      res        = rr_ffs(req_ext, ptr_ext, N_CH);
      valid_o    = res[MaxIdW];
      idx_o      = res[ID_W-1:0];
      unused_res = ^res;
   end

endmodule

// File: rtl/req_grnt_arb.sv
// Round-robin request/grant arbiter with programmable grant delay and max hold.
module req_grnt_arb
   import req_grnt_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   req_grnt_arb_if.slave arb_io
);

   localparam int unsigned ID_W = $clog2(N_CH);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  sel_q, sel_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] dly_q, dly_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [N_CH-1:0]  grnt_q, grnt_d;
   logic [ID_W-1:0]  grnt_id_q, grnt_id_d;
   logic             busy_q, busy_d;
   logic             hold_exp_q, hold_exp_d;
   logic             abandon_q, abandon_d;

   logic             pick_valid;
   logic [ID_W-1:0]  pick_idx;
   logic             req_sel;
   logic [ID_W-1:0]  ptr_next;

   rr_pick #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req_i   (arb_io.req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Winner's live request and the pointer position just past the winner.
   always_comb begin
      req_sel  = arb_io.req[sel_q];
      ptr_next = (sel_q == ID_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
   end

   // Next-state and registered-output logic for the arbitration FSM.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      dly_d      = dly_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      hcnt_d     = hcnt_q;
      grnt_d     = grnt_q;
      grnt_id_d  = grnt_id_q;
      busy_d     = busy_q;
      hold_exp_d = 1'b0;
      abandon_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               sel_d   = pick_idx;
               // Config is sampled only here; a zero delay behaves as one.
               dly_d   = (arb_io.dly_cfg == '0) ? CNT_W'(1) : arb_io.dly_cfg;
               hold_d  = arb_io.hold_cfg;
               cnt_d   = CNT_W'(1);
               busy_d  = 1'b1;
               state_d = StDelay;
            end
         end

         StDelay: begin
            if (!req_sel) begin
               // Pointer untouched so the abandoning channel keeps priority.
               abandon_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = StIdle;
            end else if (cnt_q == dly_q) begin
               grnt_d    = N_CH'(1) << sel_q;
               grnt_id_d = sel_q;
               hcnt_d    = CNT_W'(1);
               state_d   = StGrant;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StGrant: begin
            if (!req_sel) begin
               grnt_d   = '0;
               busy_d   = 1'b0;
               rr_ptr_d = ptr_next;
               state_d  = StIdle;
            end else if (hold_q != '0 && hcnt_q == hold_q) begin
               grnt_d     = '0;
               busy_d     = 1'b0;
               hold_exp_d = 1'b1;
               rr_ptr_d   = ptr_next;
               state_d    = StIdle;
            end else if (hcnt_q != '1) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end

         default: begin
            grnt_d  = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset clears everything including the pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         rr_ptr_q   <= '0;
         dly_q      <= '0;
         hold_q     <= '0;
         cnt_q      <= '0;
         hcnt_q     <= '0;
         grnt_q     <= '0;
         grnt_id_q  <= '0;
         busy_q     <= 1'b0;
         hold_exp_q <= 1'b0;
         abandon_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         dly_q      <= dly_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         hcnt_q     <= hcnt_d;
         grnt_q     <= grnt_d;
         grnt_id_q  <= grnt_id_d;
         busy_q     <= busy_d;
         hold_exp_q <= hold_exp_d;
         abandon_q  <= abandon_d;
      end
   end

   // Drive the bundle straight from registers.
   always_comb begin
      arb_io.grnt     = grnt_q;
      arb_io.grnt_id  = grnt_id_q;
      arb_io.busy     = busy_q;
      arb_io.hold_exp = hold_exp_q;
      arb_io.abandon  = abandon_q;
   end

endmodule

// File: tb/tb_req_grnt_arb.sv
// Directed bench for req_grnt_arb (N_CH=4) with an expectation queue.
module tb_req_grnt_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   step = 0;

   typedef struct packed {
      logic [3:0] grnt;
      logic [1:0] id;
      logic       busy;
      logic       hexp;
      logic       ab;
   } exp_t;

   exp_t sb[$];

   req_grnt_arb_if #(.N_CH(4), .CNT_W(4)) bus ();

   req_grnt_arb #(
      .N_CH  (4),
      .CNT_W (4)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .arb_io (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string ph, input exp_t e);
      chk($sformatf("%s grnt", ph), 8'(bus.grnt), 8'(e.grnt));
      chk($sformatf("%s grnt_id", ph), 8'(bus.grnt_id), 8'(e.id));
      chk($sformatf("%s busy", ph), 8'(bus.busy), 8'(e.busy));
      chk($sformatf("%s hold_exp", ph), 8'(bus.hold_exp), 8'(e.hexp));
      chk($sformatf("%s abandon", ph), 8'(bus.abandon), 8'(e.ab));
      chk($sformatf("%s onehot0", ph), 8'($onehot0(bus.grnt)), 8'(1));
   endtask

   // Drive req for one edge, queue the expected post-edge outputs, then compare.
   task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                      input logic b, input logic he, input logic ab);
      exp_t e;
      bus.req = r;
      sb.push_back('{grnt: g, id: id, busy: b, hexp: he, ab: ab});
      @(posedge clk);
      #1;
      step++;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL s%0d scoreboard: observed empty queue, required one entry", step);
      end else begin
         e = sb.pop_front();
         chk_out($sformatf("s%0d", step), e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req      = 4'b0000;
      bus.dly_cfg  = 4'd1;
      bus.hold_cfg = 4'd2;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", '{grnt: 4'b0, id: 2'd0, busy: 1'b0, hexp: 1'b0, ab: 1'b0});
      rst = 1'b0;

      // All four requesting, dly=1, hold=2: grants rotate 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         logic [1:0] prev;
         logic [1:0] cur;
         logic [3:0] oh;
         prev = (k == 0) ? 2'd0 : 2'(k - 1);
         cur  = 2'(k % 4);
         oh   = 4'b0001 << cur;
         cyc(4'b1111, 4'b0000, prev, 1'b1, 1'b0, 1'b0);
         cyc(4'b1111, oh,      cur,  1'b1, 1'b0, 1'b0);
         cyc(4'b1111, oh,      cur,  1'b1, 1'b0, 1'b0);
         cyc(4'b1111, 4'b0000, cur,  1'b0, 1'b1, 1'b0);
      end
      cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      // dly=1, unlimited hold: ch2 granted one edge after acceptance.
      bus.hold_cfg = 4'd0;
      cyc(4'b0100, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      // Pointer now 3: ch3 beats ch0.
      cyc(4'b1001, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);

      // dly=0 behaves as dly=1.
      bus.dly_cfg = 4'd0;
      cyc(4'b0010, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
      cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

      // dly=3: grant first high after the third edge past acceptance.
      bus.dly_cfg = 4'd3;
      cyc(4'b0001, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0001, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0001, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      // dly=4: ch1 abandons in DELAY, then still wins over ch2.
      bus.dly_cfg = 4'd4;
      cyc(4'b0010, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b0010, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0110, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(4'b0110, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

      // Config changed mid-DELAY: in-flight grant keeps dly=1, next uses 5.
      bus.dly_cfg = 4'd1;
      cyc(4'b0100, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      bus.dly_cfg = 4'd5;
      cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      cyc(4'b1000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(4'b1000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);

      // Reset mid-GRANT: outputs clear asynchronously with no pulses.
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_async", '{grnt: 4'b0, id: 2'd0, busy: 1'b0, hexp: 1'b0, ab: 1'b0});
      @(posedge clk);
      #1;
      chk_out("rst_held", '{grnt: 4'b0, id: 2'd0, busy: 1'b0, hexp: 1'b0, ab: 1'b0});
      bus.dly_cfg = 4'd2;
      rst = 1'b0;

      // Pointer back at 0: ch0 wins over ch3; then ch3 waits the full delay.
      cyc(4'b1001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b1001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc(4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
